// File: rtl/bch_error_locate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bch_error_locate_pkg
// Description : Shared definitions for the BCH error-locate slice. Holds the
//               packed BCH parameter word layout and its accessor functions,
//               the frame padding helpers (also used by the correction stage)
//               and the error-locate FSM state encoding.
//               Parameter word layout: [31:16] DATA_BITS, [15:8] T, [7:0] M.
// Revision    : 1.0 - initial release
// ============================================================================
package bch_error_locate_pkg;

    // Ceiling log2; bch_log2(1) = 0.
    function automatic int bch_log2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] bch_pack(input int m, input int t, input int data_bits);
        return {data_bits[15:0], t[7:0], m[7:0]};
    endfunction

    function automatic int bch_m(input logic [31:0] p);
        return int'(p[7:0]);
    endfunction

    function automatic int bch_t(input logic [31:0] p);
        return int'(p[15:8]);
    endfunction

    function automatic int bch_data_bits(input logic [31:0] p);
        return int'(p[31:16]);
    endfunction

    // Width of one lane's Chien term vector: T+1 terms of M bits each.
    function automatic int bch_sigma_sz(input logic [31:0] p);
        return (bch_t(p) + 1) * bch_m(p);
    endfunction

    // Beats needed to carry the data bits at the given beat width.
    function automatic int bch_cycles(input logic [31:0] p, input int bits);
        return (bch_data_bits(p) + bits - 1) / bits;
    endfunction

    // Unused low lanes of the final beat.
    function automatic int bch_pad(input logic [31:0] p, input int bits);
        return bch_cycles(p, bits) * bits - bch_data_bits(p);
    endfunction

    // BCH(15,.) with M=4, T=2 and 15 data bits: a small, sane default.
    localparam logic [31:0] c_BCH_SANE = {16'd15, 8'd2, 8'd4};

    localparam int          c_ST_W      = 2;
    localparam logic [1:0]  c_ST_IDLE   = 2'd0;
    localparam logic [1:0]  c_ST_RUN    = 2'd1;
    localparam logic [1:0]  c_ST_FINISH = 2'd2;

endpackage
`default_nettype wire

// File: rtl/bch_error_zero_detect.sv
`default_nettype none
// ============================================================================
// Module      : bch_error_zero_detect
// Description : One data-bit lane of the error locator. XOR-reduces the T+1
//               Chien terms of the lane; z=1 when the sum is zero, i.e. the
//               locator polynomial has a root at this bit position.
// Ports       : terms  in  (T+1)*M  term i at [i*M +: M]
//               z      out 1        lane sum is zero
// Revision    : 1.0 - initial release
// ============================================================================
module bch_error_zero_detect #(
    parameter int M = 4,
    parameter int T = 2
) (
    input  logic [(T+1)*M-1:0] terms,
    output logic               z
);

    logic [M-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i <= T; i++) begin
            w_sum = w_sum ^ terms[i*M +: M];
        end
    end

    assign z = (w_sum == '0);

endmodule
`default_nettype wire

// File: rtl/bch_error_locate.sv
`default_nettype none
// ============================================================================
// Module      : bch_error_locate
// Description : Turns Chien-search term vectors into a per-beat error mask,
//               counts located errors per codeword and checks the count
//               against the error-locator degree at end of frame.
// Ports       : clk, reset          clock, synchronous active-high reset
//               start               new codeword, latches sigma_deg
//               sigma_deg           error-locator degree
//               in_first/last/valid Chien framing
//               chien               BITS lanes of (T+1)*M term bits
//               err                 error mask, err[BITS-1] earliest bit
//               err_first/last/valid registered framing
//               err_count           saturating error count (T+1 max)
//               done, failed        end-of-frame status (failed valid w/ done)
// Revision    : 1.0 - initial release
// ============================================================================
module bch_error_locate
    import bch_error_locate_pkg::*;
#(
    parameter logic [31:0] P    = c_BCH_SANE,
    parameter int          BITS = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [bch_log2(bch_t(P)+1)-1:0]    sigma_deg,
    input  logic                               in_first,
    input  logic                               in_last,
    input  logic                               in_valid,
    input  logic [bch_sigma_sz(P)*BITS-1:0]    chien,
    output logic [BITS-1:0]                    err,
    output logic                               err_first,
    output logic                               err_last,
    output logic                               err_valid,
    output logic [bch_log2(bch_t(P)+1):0]      err_count,
    output logic                               done,
    output logic                               failed
);

    localparam int c_M   = bch_m(P);
    localparam int c_T   = bch_t(P);
    localparam int c_DW  = bch_log2(c_T + 1);
    localparam int c_CW  = c_DW + 1;
    localparam int c_SIG = bch_sigma_sz(P);
    localparam int c_PAD = bch_pad(P, BITS);
    // Sum width wide enough for count + a full beat before saturation.
    localparam int c_SW  = c_CW + bch_log2(BITS + 1);

    localparam logic [c_CW-1:0] c_T_CW   = c_CW'(c_T);
    localparam logic [c_CW-1:0] c_SAT    = c_CW'(c_T + 1);
    localparam logic [c_SW-1:0] c_SAT_SW = c_SW'(c_T + 1);

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_state_nxt;
    logic [c_DW-1:0]   r_deg;
    logic [c_CW-1:0]   r_count;
    logic [c_CW-1:0]   w_count_nxt;
    logic [c_SW-1:0]   w_pop;
    logic [c_SW-1:0]   w_sum;
    logic [BITS-1:0]   w_zero;
    logic [BITS-1:0]   w_mask;
    logic [BITS-1:0]   w_err;
    logic              w_count_en;
    logic              w_done;
    logic              w_failed;

    logic [BITS-1:0]   r_err;
    logic              r_err_first;
    logic              r_err_last;
    logic              r_err_valid;
    logic [c_CW-1:0]   r_err_count;
    logic              r_done;
    logic              r_failed;

    // ------------------------------------------------------------------
    // Lane detectors
    // ------------------------------------------------------------------
    for (genvar k = 0; k < BITS; k++) begin : g_lane
        bch_error_zero_detect #(
            .M (c_M),
            .T (c_T)
        ) u_zero_detect (
            .terms (chien[k*c_SIG +: c_SIG]),
            .z     (w_zero[k])
        );
    end

    // The last beat may be partially filled; its low lanes carry no data.
    always_comb begin
        w_mask = '1;
        for (int k = 0; k < BITS; k++) begin
            if (in_last && (k < c_PAD)) begin
                w_mask[k] = 1'b0;
            end
        end
    end

    assign w_err = in_valid ? (w_zero & w_mask) : '0;

    // Popcount of the beat plus running count, clamped at T+1.
    always_comb begin
        w_pop = '0;
        for (int k = 0; k < BITS; k++) begin
            w_pop = w_pop + c_SW'(w_err[k]);
        end
        w_sum       = c_SW'(r_count) + w_pop;
        w_count_nxt = (w_sum >= c_SAT_SW) ? c_SAT : w_sum[c_CW-1:0];
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state. start overrides every state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   w_state_nxt = c_ST_IDLE;
            c_ST_RUN:    if (in_valid && in_last) w_state_nxt = c_ST_FINISH;
            c_ST_FINISH: w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
        if (start) begin
            w_state_nxt = c_ST_RUN;
        end
    end

    // FSM: outputs. The count is already final while in FINISH because the
    // last beat was accumulated on the edge that entered FINISH.
    always_comb begin
        w_count_en = (r_state == c_ST_RUN) && in_valid && !start;
        w_done     = (r_state == c_ST_FINISH);
        w_failed   = ({1'b0, r_deg} != r_count) || ({1'b0, r_deg} > c_T_CW);
    end

    // ------------------------------------------------------------------
    // Degree latch and error count
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_deg   <= '0;
            r_count <= '0;
        end else if (start) begin
            r_deg   <= sigma_deg;
            r_count <= '0;
        end else if (w_count_en) begin
            r_count <= w_count_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Output registers. done/failed trail the FINISH state by one cycle so
    // that they land the cycle after err_last.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err       <= '0;
            r_err_first <= 1'b0;
            r_err_last  <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_count <= '0;
            r_done      <= 1'b0;
            r_failed    <= 1'b0;
        end else begin
            r_err       <= w_err;
            r_err_first <= in_first;
            r_err_last  <= in_last;
            r_err_valid <= in_valid;
            r_err_count <= r_count;
            r_done      <= w_done;
            r_failed    <= w_done && w_failed;
        end
    end

    assign err       = r_err;
    assign err_first = r_err_first;
    assign err_last  = r_err_last;
    assign err_valid = r_err_valid;
    assign err_count = r_err_count;
    assign done      = r_done;
    assign failed    = r_failed;

endmodule
`default_nettype wire

// File: doc/bch_error_locate.md
Name: bch_error_locate

Overview:
- Consumes the Chien-search term vectors and their first/last/valid framing, one beat per cycle.
- Per data-bit lane: XOR-reduces the T+1 terms and flags an error wherever the sum is zero.
- Counts located errors per codeword and compares the count with the sigma degree from the key-equation stage.
- Emits a per-beat error mask for the correction XOR, plus an end-of-frame done/failed status.

Parameters:
- P, `BCH_SANE: packed BCH parameter word. M, T, DATA_BITS and K are derived through bch_defs.vh macros.
- BITS, 1: data bits per beat. Must equal the upstream Chien BITS.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  new codeword; pulse coincident with the Chien stage's start
- sigma_deg  in  DW=log2(T+1)  degree of the error-locator polynomial; sampled when start=1
- in_first  in  1  first beat of frame (Chien first)
- in_last  in  1  last beat of frame (Chien last)
- in_valid  in  1  beat valid (Chien valid)
- chien  in  `BCH_SIGMA_SZ(P)*BITS  term vectors; lane k occupies bits [k*(T+1)*M +: (T+1)*M], term i of lane k at [(k*(T+1)+i)*M +: M]
- err  out  BITS  error mask; err[BITS-1] is the earliest data bit of the beat
- err_first  out  1  registered copy of in_first
- err_last  out  1  registered copy of in_last
- err_valid  out  1  registered copy of in_valid
- err_count  out  CW=log2(T+1)+1  errors located so far, saturating at T+1
- done  out  1  one-cycle pulse after the final beat
- failed  out  1  valid only when done=1; 1 means the codeword is uncorrectable

Behaviour:
- Reset: every output, the count register, the latched degree and the state all go to 0. A reset mid-frame drops the frame: no done pulse, and the block waits in IDLE for the next start.
- States:
  - IDLE: start=1 → RUN; latch sigma_deg; clear the count.
  - RUN: accept beats. A beat with in_valid=1 and in_last=1 → FINISH.
  - FINISH: lasts one cycle and drives done=1 → IDLE.
  - start=1 in any state takes priority: re-latch sigma_deg, clear the count, → RUN. An in-flight beat arriving in that same cycle is still registered to the outputs but is not counted.
- Lane detect (combinational): z[k] = (XOR over i=0..T of term(k,i)) == 0.
- Padding mask: PAD = CYCLES*BITS − DATA_BITS, where CYCLES = ceil(DATA_BITS/BITS). On the in_last beat, lanes err[PAD-1:0] are forced to 0.
- Gating: err = z & mask when in_valid=1, otherwise 0.
- Latency: err, err_first, err_last and err_valid are registered with exactly 1 cycle of latency.
- Counting: each valid beat adds popcount(err) to the count, saturating at T+1. err_count is the registered count and reflects beats up to and including the previous err beat.
- done rises the cycle after err_last=1 with err_valid=1, i.e. 2 cycles after in_last.
- failed rule at done: failed = (final count ≠ latched degree) OR (latched degree > T). A degree of 0 with a count of 0 gives failed=0.
- Beats received while in IDLE are passed through to the outputs but not counted, and they produce no done.
- in_valid=0 mid-frame (bubble): err=0, the count holds.

Decomposition:
- Shared (bch.vh / bch_defs.vh): log2 function, `BCH_SIGMA_SZ, `BCH_M, `BCH_T, `BCH_DATA_BITS. The CYCLES/PAD expressions also go there for reuse by the correction stage.
- Sub-module bch_error_zero_detect: combinational, one lane (T+1 terms → z). Instantiated BITS times in a generate loop.
- The popcount/saturating adder stays inline.

Test Plan:
- No errors. M=4, T=2, BITS=1. Each beat term0=4'h1, term1=4'h0, term2=4'h0 for 15 beats; sigma_deg=0 → err always 0, done 2 cycles after in_last, failed=0, err_count=0.
- Two errors. Beats 3 and 9 carry terms {4'h5, 4'h5, 4'h0}, all others nonzero sums; sigma_deg=2 → err=1 exactly on output beats 3 and 9 (1 cycle late), err_count=2, done with failed=0.
- Degree mismatch. Same stimulus as the two-error case but sigma_deg=3 → failed=1. Separately, 4 zero beats with T=2 → err_count saturates at 3, failed=1.
- Padding. BITS=4 with DATA_BITS=14, so PAD=2. All lanes zero-sum on every beat → on the last beat err=4'b1100, and the total count counts 14 data bits, saturating at T+1.
- Restart. start asserted mid-frame on beat 5 with a new sigma_deg=1 → count clears, no done for the old frame, the new frame completes normally.
- Reset. reset=1 for 1 cycle mid-frame → all outputs 0 the next cycle, no done; a following start/frame behaves as in the no-error case.
